ext_mem_responder: RTL and testbench
====================================

Name: ext_mem_responder

Overview:
- External-side memory slave sitting directly downstream of the CPU memory controller.
- Decodes the controller's 3-bit external drive code, address and write data, and serves instruction fetches, data reads and data writes from an internal word-addressed RAM after a programmable number of wait states.
- Raises the ready handshake the controller waits on.
- Used as the board-level memory model in simulation and as the on-chip RAM bridge in synthesis.

Parameters:
- ADDR_W, 10, word-address width; RAM depth = 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 2, wait states inserted between command acceptance and ready (0..15).
- BASE_ADDR, 32'h0000_0000, byte address of RAM word 0.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  reset; synchronous, active-low.
- ext_cmd  input  3  external drive code: 000 idle, 001 instruction fetch, 010 memory read, 011 memory write, 100/101 IO read/write (reserved), 110/111 reserved.
- ext_addr  input  32  byte address from controller.
- ext_wdata  input  32  write data (controller-driven data bus value).
- ext_rdata  output  32  read/fetch data to controller.
- ext_rdata_oe  output  1  1 = this block drives the shared data bus with ext_rdata; top level builds the tristate from it.
- ext_ready  output  1  exchange complete; maps to controller's ExternalExchangeReady.
- bus_err  output  1  set with ext_ready when the address is out of range, misaligned, or the code is reserved.
- busy  output  1  1 in WAIT state.

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, ext_rdata=0, ext_rdata_oe=0, ext_ready=0, bus_err=0, busy=0, wait counter=0. RAM contents are not cleared.
- Reset mid-transaction aborts it. A pending write is not committed unless its commit edge had already occurred.
- States: IDLE, WAIT, DONE.
- IDLE:
  - ext_cmd in {001,010,011}: latch cmd, ext_addr and ext_wdata; load counter=WAIT_CYCLES; go to WAIT.
  - ext_cmd in {100..111}: go directly to DONE with ext_ready=1, bus_err=1, ext_rdata=0, no RAM access.
  - ext_cmd=000: stay in IDLE.
- WAIT:
  - busy=1.
  - Counter>0: decrement.
  - Counter=0: perform the access at this edge, go to DONE, ext_ready=1.
- Latency: command accepted at edge N gives ext_ready=1 after edge N+WAIT_CYCLES+1. With WAIT_CYCLES=0, ext_ready=1 after edge N+1.
- Address check:
  - Word index = (addr - BASE_ADDR) >> 2.
  - In range iff addr >= BASE_ADDR and the index < 2^ADDR_W. Compute the subtraction in 33 bits; no wrap-around aliasing.
  - addr[1:0] != 0 is misaligned.
  - Range or alignment failure: bus_err=1, ext_rdata=0, no RAM write.
- Access:
  - Fetch/read: ext_rdata <= RAM[index], registered at the completion edge; ext_rdata_oe=1 while in DONE.
  - Write: RAM[index] <= latched wdata at the completion edge; ext_rdata_oe=0 throughout.
- DONE:
  - ext_ready, ext_rdata and ext_rdata_oe are held while ext_cmd equals the latched cmd. The controller may leave the read code asserted for many cycles; the data must stay stable.
  - ext_cmd becomes 000: go to IDLE, clear ext_ready, bus_err and ext_rdata_oe next edge. ext_rdata keeps its last value.
  - ext_cmd changes to another valid code, or the same code with a different ext_addr: treat as a new command. Clear ready, latch, go to WAIT in the same edge; no IDLE cycle required.
- Commands arriving during WAIT are ignored. The latched command completes, then DONE applies the rules above.
- Write followed immediately by a read of the same address returns the new data: the write commits before the read's completion edge.
- ext_addr and ext_wdata changes during WAIT have no effect (latched values are used).

Test Plan:
- Reset with WAIT_CYCLES=2: hold rst=0 for 3 cycles, release -> all outputs 0, state IDLE. ext_cmd=000 for 5 cycles -> ext_ready stays 0.
- Write then read: cmd=011, addr=0x10, wdata=0xCAFEBABE; ready appears 3 cycles after acceptance with oe=0. Then cmd=000, then cmd=010, addr=0x10 -> ext_ready after 3 cycles, ext_rdata=0xCAFEBABE, oe=1, held stable for 20 cycles while cmd stays 010.
- Fetch back-to-back: cmd=001 at addr 0x0 then directly 001 at addr 0x4 while in DONE -> ready drops for 3 cycles, then rdata = RAM[1]. Return to 000 -> ready=0 next edge.
- Errors: cmd=010 at addr 0x1000 (index 1024, ADDR_W=10) -> ready=1, bus_err=1, rdata=0. cmd=011 at addr 0x6 -> bus_err=1 and RAM[1] unchanged. cmd=101 -> ready and bus_err asserted 1 cycle after acceptance.
- Reset mid-write: cmd=011, addr=0x20, wdata=0x12345678; assert rst=0 during WAIT -> outputs cleared; a later read of 0x20 returns the prior contents.
- WAIT_CYCLES=0 instance: cmd=010 -> ext_ready high on the first edge after acceptance; busy pulses for exactly 1 cycle.

Source files
------------

// File: rtl/ext_mem_responder.sv
// ext_mem_responder: external-side memory slave for the CPU memory controller.
// It decodes the 3-bit drive code and serves instruction fetches, data reads
// and data writes from an internal word-addressed RAM. The ready handshake is
// raised after WAIT_CYCLES wait states. Reserved codes complete immediately
// with bus_err set.
module ext_mem_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  ext_cmd,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    output logic [31:0] ext_rdata,
    output logic        ext_rdata_oe,
    output logic        ext_ready,
    output logic        bus_err,
    output logic        busy
);

    localparam logic [2:0] CMD_IDLE  = 3'b000;
    localparam logic [2:0] CMD_FETCH = 3'b001;
    localparam logic [2:0] CMD_READ  = 3'b010;
    localparam logic [2:0] CMD_WRITE = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state;
    logic [2:0]  cmd_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  cnt;

    logic [31:0] ram [0:(2**ADDR_W)-1];

    logic [32:0]       off;
    logic [ADDR_W-1:0] idx;
    logic              addr_ok;
    logic              ram_we;
    logic              cmd_valid;
    logic              cmd_rsvd;
    logic              take_cmd;

    // Address decode of the latched request, and command classification of the live bus.
    always_comb begin
        off       = {1'b0, addr_q} - {1'b0, BASE_ADDR};
        idx       = off[ADDR_W+1:2];
        // A borrow into bit 32 (address below base) or any offset bit at or
        // above ADDR_W+2 puts the access out of range; no aliasing.
        addr_ok   = ((off >> (ADDR_W + 2)) == '0) && (addr_q[1:0] == 2'b00);
        ram_we    = rst && (state == S_WAIT) && (cnt == '0) &&
                    (cmd_q == CMD_WRITE) && addr_ok;
        cmd_valid = (ext_cmd == CMD_FETCH) || (ext_cmd == CMD_READ) ||
                    (ext_cmd == CMD_WRITE);
        cmd_rsvd  = ext_cmd[2];
        take_cmd  = 1'b0;
        if (state == S_IDLE) begin
            take_cmd = (ext_cmd != CMD_IDLE);
        end else if (state == S_DONE) begin
            take_cmd = (ext_cmd != CMD_IDLE) &&
                       !((ext_cmd == cmd_q) && (ext_addr == addr_q));
        end
    end

    // RAM write port: commits a latched write at its completion edge.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[idx] <= wdata_q;
        end
    end

    // Control FSM with registered handshake, data and status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            cmd_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            ext_rdata    <= '0;
            ext_rdata_oe <= 1'b0;
            ext_ready    <= 1'b0;
            bus_err      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (take_cmd) begin
                        cmd_q   <= ext_cmd;
                        addr_q  <= ext_addr;
                        wdata_q <= ext_wdata;
                        if (cmd_valid) begin
                            cnt          <= 4'(WAIT_CYCLES);
                            state        <= S_WAIT;
                            busy         <= 1'b1;
                            ext_ready    <= 1'b0;
                            bus_err      <= 1'b0;
                            ext_rdata_oe <= 1'b0;
                        end else if (cmd_rsvd) begin
                            state        <= S_DONE;
                            ext_ready    <= 1'b1;
                            bus_err      <= 1'b1;
                            ext_rdata    <= '0;
                            ext_rdata_oe <= 1'b0;
                            busy         <= 1'b0;
                        end
                    end else if ((state == S_DONE) && (ext_cmd == CMD_IDLE)) begin
                        state        <= S_IDLE;
                        ext_ready    <= 1'b0;
                        bus_err      <= 1'b0;
                        ext_rdata_oe <= 1'b0;
                    end
                end

                S_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        ext_ready <= 1'b1;
                        bus_err   <= !addr_ok;
                        if (cmd_q == CMD_WRITE) begin
                            ext_rdata_oe <= 1'b0;
                            if (!addr_ok) begin
                                ext_rdata <= '0;
                            end
                        end else begin
                            ext_rdata_oe <= 1'b1;
                            ext_rdata    <= addr_ok ? ram[idx] : '0;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ext_mem_responder.sv
// Bench for ext_mem_responder: a WAIT_CYCLES=2 instance (index 0) and a
// WAIT_CYCLES=0 instance (index 1), checked against a word-level memory model.
module tb_ext_mem_responder;

    logic        clk;
    logic        rst;
    logic [2:0]  cmd_s   [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [31:0] rdata_s [2];
    logic        oe_s    [2];
    logic        ready_s [2];
    logic        err_s   [2];
    logic        busy_s  [2];

    int checks   = 0;
    int failures = 0;

    // Reference state: memory contents keyed by instance and word, last bus data.
    logic [31:0] model [int unsigned];
    logic [31:0] last_rdata [2];
    bit          in_done [2];
    bit          last_rsvd [2];
    logic [2:0]  prev_c [2];
    logic [31:0] prev_a [2];

    ext_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst), .ext_cmd(cmd_s[0]), .ext_addr(addr_s[0]),
        .ext_wdata(wdata_s[0]), .ext_rdata(rdata_s[0]), .ext_rdata_oe(oe_s[0]),
        .ext_ready(ready_s[0]), .bus_err(err_s[0]), .busy(busy_s[0])
    );

    ext_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
        .clk(clk), .rst(rst), .ext_cmd(cmd_s[1]), .ext_addr(addr_s[1]),
        .ext_wdata(wdata_s[1]), .ext_rdata(rdata_s[1]), .ext_rdata_oe(oe_s[1]),
        .ext_ready(ready_s[1]), .bus_err(err_s[1]), .busy(busy_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        longint base;
        longint av;
        base = 0;
        av   = longint'(a);
        return (av >= base) && (((av - base) / 4) < 1024) && ((av % 4) == 0);
    endfunction

    function automatic int unsigned key(input int sel, input logic [31:0] a);
        return int'(sel) * 4096 + int'(a / 4);
    endfunction

    task automatic check_idle_outputs(input int sel, input string tag);
        chk({tag, "_ready"}, 64'(ready_s[sel]), 64'd0);
        chk({tag, "_err"},   64'(err_s[sel]),   64'd0);
        chk({tag, "_oe"},    64'(oe_s[sel]),    64'd0);
        chk({tag, "_busy"},  64'(busy_s[sel]),  64'd0);
        chk({tag, "_rdata"}, 64'(rdata_s[sel]), 64'(last_rdata[sel]));
    endtask

    // One command from IDLE or chained from DONE; follows it to completion.
    task automatic txn(input int sel, input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] d);
        int  n;
        int  bz;
        bit  rsvd;
        bit  ok;
        int  w;
        rsvd = c[2];
        ok   = addr_ok(a);
        w    = (sel == 0) ? 2 : 0;
        @(negedge clk);
        cmd_s[sel] = c; addr_s[sel] = a; wdata_s[sel] = d;
        n = 0; bz = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (ready_s[sel]) break;
            bz += int'(busy_s[sel]);
        end
        if (rsvd) begin
            chk("rsvd_latency", 64'(n), 64'd1);
            chk("rsvd_busy",    64'(bz), 64'd0);
            chk("rsvd_err",     64'(err_s[sel]), 64'd1);
            last_rdata[sel] = '0;
            chk("rsvd_rdata",   64'(rdata_s[sel]), 64'(last_rdata[sel]));
        end else begin
            chk("latency",     64'(n - 1), 64'(w + 1));
            chk("busy_cycles", 64'(bz), 64'(w + 1));
            chk("busy_done",   64'(busy_s[sel]), 64'd0);
            chk("err",         64'(err_s[sel]), 64'(!ok));
            if (!ok) begin
                last_rdata[sel] = '0;
            end else if (c == 3'b011) begin
                model[key(sel, a)] = d;
            end else begin
                last_rdata[sel] = model[key(sel, a)];
            end
            if (c == 3'b011) chk("wr_oe", 64'(oe_s[sel]), 64'd0);
            else if (ok)     chk("rd_oe", 64'(oe_s[sel]), 64'd1);
            chk("rdata", 64'(rdata_s[sel]), 64'(last_rdata[sel]));
        end
        in_done[sel]   = 1'b1;
        last_rsvd[sel] = rsvd;
        prev_c[sel]    = c;
        prev_a[sel]    = a;
    endtask

    task automatic release_cmd(input int sel);
        @(negedge clk);
        cmd_s[sel] = 3'b000;
        @(posedge clk); #1;
        check_idle_outputs(sel, "release");
        in_done[sel] = 1'b0;
    endtask

    task automatic hold(input int sel, input int cycles, input logic exp_oe);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            chk("hold_ready", 64'(ready_s[sel]), 64'd1);
            chk("hold_rdata", 64'(rdata_s[sel]), 64'(last_rdata[sel]));
            chk("hold_oe",    64'(oe_s[sel]),    64'(exp_oe));
        end
    endtask

    initial begin
        logic [2:0]  c;
        logic [31:0] a;
        logic [31:0] d;
        int          sel;
        int          r;
        bit          chain;

        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            cmd_s[s] = '0; addr_s[s] = '0; wdata_s[s] = '0;
            last_rdata[s] = '0; in_done[s] = 1'b0; last_rsvd[s] = 1'b0;
            prev_c[s] = '0; prev_a[s] = '0;
        end

        // Reset held for three edges.
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs(0, "reset");
        check_idle_outputs(1, "reset0");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("idle_ready", 64'(ready_s[0]), 64'd0);
        end

        // Write then read back, read data held while the code stays asserted.
        txn(0, 3'b011, 32'h10, 32'hCAFEBABE);
        release_cmd(0);
        txn(0, 3'b010, 32'h10, 32'h0);
        chk("rd_cafe", 64'(rdata_s[0]), 64'hCAFEBABE);
        hold(0, 20, 1'b1);
        release_cmd(0);

        // Back-to-back fetches without an IDLE cycle.
        txn(0, 3'b011, 32'h0, 32'h1111_0000);
        release_cmd(0);
        txn(0, 3'b011, 32'h4, 32'h2222_0004);
        release_cmd(0);
        txn(0, 3'b001, 32'h0, 32'h0);
        txn(0, 3'b001, 32'h4, 32'h0);
        chk("fetch_word1", 64'(rdata_s[0]), 64'h2222_0004);
        release_cmd(0);

        // Error responses.
        txn(0, 3'b010, 32'h1000, 32'h0);
        release_cmd(0);
        txn(0, 3'b011, 32'h6, 32'hDEAD_BEEF);
        release_cmd(0);
        txn(0, 3'b010, 32'h4, 32'h0);
        chk("misaligned_no_write", 64'(rdata_s[0]), 64'h2222_0004);
        release_cmd(0);
        txn(0, 3'b101, 32'h40, 32'h0);
        release_cmd(0);

        // Reset during a pending write aborts it.
        txn(0, 3'b011, 32'h20, 32'h0BAD_F00D);
        release_cmd(0);
        @(negedge clk);
        cmd_s[0] = 3'b011; addr_s[0] = 32'h20; wdata_s[0] = 32'h1234_5678;
        @(posedge clk); #1;
        chk("midwr_busy", 64'(busy_s[0]), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        cmd_s[0] = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        last_rdata[0] = '0; last_rdata[1] = '0;
        in_done[0] = 1'b0; in_done[1] = 1'b0;
        check_idle_outputs(0, "midwr_reset");
        @(negedge clk);
        rst = 1'b1;
        txn(0, 3'b010, 32'h20, 32'h0);
        chk("midwr_old_data", 64'(rdata_s[0]), 64'h0BAD_F00D);
        release_cmd(0);

        // Zero-wait instance.
        txn(1, 3'b011, 32'h8, 32'h5A5A_A5A5);
        release_cmd(1);
        txn(1, 3'b010, 32'h8, 32'h0);
        hold(1, 3, 1'b1);
        release_cmd(1);

        // Randomized traffic on both instances.
        for (int i = 0; i < 60; i++) begin
            sel = ($urandom_range(0, 3) == 0) ? 1 : 0;
            r   = int'($urandom_range(0, 9));
            d   = $urandom;
            a   = 32'($urandom_range(0, 63)) * 4;
            if (r < 4) begin
                c = 3'b011;
            end else if (r < 8) begin
                c = 3'($urandom_range(1, 2));
                if (!model.exists(key(sel, a))) c = 3'b011;
            end else if (r == 8) begin
                c = 3'($urandom_range(1, 3));
                if ($urandom_range(0, 1) == 0) a = 32'h1000 + 32'($urandom_range(0, 1000)) * 4;
                else a = a + 32'($urandom_range(1, 3));
            end else begin
                c = 3'($urandom_range(4, 7));
            end
            chain = ($urandom_range(0, 1) == 1) && !c[2] && in_done[sel] &&
                    !last_rsvd[sel] && ((c != prev_c[sel]) || (a != prev_a[sel]));
            if (in_done[sel] && !chain) release_cmd(sel);
            txn(sel, c, a, d);
            if (c[2]) release_cmd(sel);
        end
        if (in_done[0]) release_cmd(0);
        if (in_done[1]) release_cmd(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
